// File: rtl/ddr_sched_pkg.sv
// rtl/ddr_sched_pkg.sv - command encodings, FSM states and default timing for the DDR scheduler
package ddr_sched_pkg;

  localparam int DEF_ROW_W  = 13;
  localparam int DEF_COL_W  = 10;
  localparam int DEF_T_RCD  = 3;
  localparam int DEF_T_RAS  = 6;
  localparam int DEF_T_WR   = 3;
  localparam int DEF_T_RP   = 3;
  localparam int DEF_T_RFC  = 8;
  localparam int DEF_T_REFI = 100;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN     = 2'd1,
    ST_PRE_WAIT = 2'd2,
    ST_REF_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/ddr_refresh_timer.sv
// rtl/ddr_refresh_timer.sv - free-running tREFI counter with a saturating refresh-owed flag
module ddr_refresh_timer
  import ddr_sched_pkg::*;
#(
  parameter int T_REFI = DEF_T_REFI,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic ref_issued,
  output logic refresh_pending
);

  localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] refi_q, refi_d;
  logic             pending_q, pending_d;

  // Expiry wins over a coincident REF so a fresh interval is never lost; a second expiry just re-sets the flag.
  always_comb begin
    refi_d    = refi_q + ONE;
    pending_d = pending_q & ~ref_issued;
    if (refi_q == REFI_LAST) begin
      refi_d    = '0;
      pending_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refi_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      refi_q    <= refi_d;
      pending_q <= pending_d;
    end
  end

  assign refresh_pending = pending_q;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - single-bank DDR command scheduler; DDR_CLOSE_PAGE_EN selects close-page policy
module ddr_cmd_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int T_RCD  = DEF_T_RCD,
  parameter int T_RAS  = DEF_T_RAS,
  parameter int T_WR   = DEF_T_WR,
  parameter int T_RP   = DEF_T_RP,
  parameter int T_RFC  = DEF_T_RFC,
  parameter int T_REFI = DEF_T_REFI,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [ROW_W-1:0] req0_row,
  input  logic [COL_W-1:0] req0_col,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [ROW_W-1:0] req1_row,
  input  logic [COL_W-1:0] req1_col,
  output logic             req1_ready,
  output logic             cmd_valid,
  output logic [2:0]       cmd,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic             grant_id,
  output logic             refresh_pending,
  output logic             busy
);

  // Counters are loaded with T-1 when the command appears, so a zero count in the
  // deciding cycle means the command registered now lands exactly T cycles later.
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LD = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic             rr_q, rr_d, lock_q, lock_d, lock_id_q, lock_id_d;
  logic [CNT_W-1:0] rcd_q, ras_q, wr_q, rp_q, rfc_q;
  logic [CNT_W-1:0] rcd_d, ras_d, wr_d, rp_d, rfc_d;
  cmd_e             cmd_q, nxt_cmd;
  logic             cmd_valid_q, grant_q, rdy0_q, rdy1_q;
  logic [ROW_W-1:0] cmd_row_q;
  logic [COL_W-1:0] cmd_col_q;

  logic             sel_valid, sel_id, sel_we, idle_like, pre_ok, issue_rdwr, close_due;
  logic [ROW_W-1:0] sel_row;
  logic [COL_W-1:0] sel_col;

`ifdef DDR_CLOSE_PAGE_EN
  logic served_q, served_d;
  assign close_due = served_q;
`else
  assign close_due = 1'b0;
`endif

  ddr_refresh_timer #(
    .T_REFI (T_REFI),
    .CNT_W  (CNT_W)
  ) u_refresh_timer (
    .clk             (clk),
    .reset           (reset),
    .ref_issued      (nxt_cmd == CMD_REF),
    .refresh_pending (refresh_pending)
  );

  function automatic logic [CNT_W-1:0] tick(input logic [CNT_W-1:0] c, input logic load,
                                           input logic [CNT_W-1:0] ld);
    if (load)          return ld;
    else if (c != '0)  return c - ONE;
    else               return c;
  endfunction

  // A locked port keeps ownership until served; otherwise rr_q breaks a tie between two new requests.
  assign sel_id    = lock_q ? lock_id_q : ((req0_valid & req1_valid) ? rr_q : req1_valid);
  assign sel_valid = lock_q | req0_valid | req1_valid;
  assign sel_we    = sel_id ? req1_we  : req0_we;
  assign sel_row   = sel_id ? req1_row : req0_row;
  assign sel_col   = sel_id ? req1_col : req0_col;
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_PRE_WAIT && rp_q == '0) ||
                     (state_q == ST_REF_WAIT && rfc_q == '0);
  assign pre_ok    = (ras_q == '0) && (wr_q == '0);

  // Pick this cycle's command: refresh first, then the close-page precharge, then the selected request.
  always_comb begin
    nxt_cmd = CMD_NOP;
    if (refresh_pending) begin
      if (state_q == ST_OPEN) begin
        if (pre_ok) nxt_cmd = CMD_PRE;
      end else if (idle_like) begin
        nxt_cmd = CMD_REF;
      end
    end else if (state_q == ST_OPEN && close_due) begin
      if (pre_ok) nxt_cmd = CMD_PRE;
    end else if (sel_valid) begin
      if (idle_like) begin
        nxt_cmd = CMD_ACT;
      end else if (state_q == ST_OPEN) begin
        if (open_row_q == sel_row) begin
          if (rcd_q == '0) nxt_cmd = sel_we ? CMD_WR : CMD_RD;
        end else if (pre_ok) begin
          nxt_cmd = CMD_PRE;
        end
      end
    end
  end

  assign issue_rdwr = (nxt_cmd == CMD_RD) || (nxt_cmd == CMD_WR);

  // Next-state for the FSM, arbitration and timing counters.
  always_comb begin
    lock_d     = sel_valid & ~issue_rdwr;
    lock_id_d  = sel_id;
    rr_d       = issue_rdwr ? ~sel_id : rr_q;
    open_row_d = (nxt_cmd == CMD_ACT) ? sel_row : open_row_q;
    rcd_d      = tick(rcd_q, nxt_cmd == CMD_ACT, RCD_LD);
    ras_d      = tick(ras_q, nxt_cmd == CMD_ACT, RAS_LD);
    wr_d       = tick(wr_q,  nxt_cmd == CMD_WR,  WR_LD);
    rp_d       = tick(rp_q,  nxt_cmd == CMD_PRE, RP_LD);
    rfc_d      = tick(rfc_q, nxt_cmd == CMD_REF, RFC_LD);
    case (nxt_cmd)
      CMD_ACT, CMD_RD, CMD_WR: state_d = ST_OPEN;
      CMD_PRE:                 state_d = ST_PRE_WAIT;
      CMD_REF:                 state_d = ST_REF_WAIT;
      default:                 state_d = idle_like ? ST_IDLE : state_q;
    endcase
`ifdef DDR_CLOSE_PAGE_EN
    served_d = issue_rdwr | (served_q & (nxt_cmd != CMD_ACT));
`endif
  end

  // FSM, arbitration, counters and registered command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      open_row_q  <= '0;
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      rcd_q       <= '0;
      ras_q       <= '0;
      wr_q        <= '0;
      rp_q        <= '0;
      rfc_q       <= '0;
      cmd_q       <= CMD_NOP;
      cmd_valid_q <= 1'b0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      grant_q     <= 1'b0;
      rdy0_q      <= 1'b0;
      rdy1_q      <= 1'b0;
`ifdef DDR_CLOSE_PAGE_EN
      served_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      open_row_q  <= open_row_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      rcd_q       <= rcd_d;
      ras_q       <= ras_d;
      wr_q        <= wr_d;
      rp_q        <= rp_d;
      rfc_q       <= rfc_d;
      cmd_q       <= nxt_cmd;
      cmd_valid_q <= (nxt_cmd != CMD_NOP);
      cmd_row_q   <= (nxt_cmd == CMD_ACT) ? sel_row : '0;
      cmd_col_q   <= issue_rdwr ? sel_col : '0;
      grant_q     <= issue_rdwr & sel_id;
      rdy0_q      <= issue_rdwr & ~sel_id;
      rdy1_q      <= issue_rdwr & sel_id;
`ifdef DDR_CLOSE_PAGE_EN
      served_q    <= served_d;
`endif
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign cmd_row    = cmd_row_q;
  assign cmd_col    = cmd_col_q;
  assign grant_id   = grant_q;
  assign req0_ready = rdy0_q;
  assign req1_ready = rdy1_q;
  assign busy       = (state_q == ST_OPEN) | refresh_pending |
                      (|{rcd_q, ras_q, wr_q, rp_q, rfc_q});

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb/tb_ddr_cmd_scheduler.sv - scoreboard testbench for ddr_cmd_scheduler
module tb_ddr_cmd_scheduler;
  import ddr_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [12:0] req0_row, req1_row;
  logic [9:0]  req0_col, req1_col;
  logic        req0_ready, req1_ready, cmd_valid, grant_id, refresh_pending, busy;
  logic [2:0]  cmd;
  logic [12:0] cmd_row;
  logic [9:0]  cmd_col;

  ddr_cmd_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_row(req0_row), .req0_col(req0_col),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_row(req1_row), .req1_col(req1_col),
    .req1_ready(req1_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .grant_id(grant_id), .refresh_pending(refresh_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [12:0] row;
    logic [9:0] col;
    logic       gid;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int c, input logic [2:0] k, input logic [12:0] r,
                      input logic [9:0] col, input logic g);
    exp_t e;
    e.cyc = c; e.cmd = k; e.row = r; e.col = col; e.gid = g;
    exp_q.push_back(e);
  endtask

  task automatic drive0(input logic v, input logic we, input logic [12:0] r, input logic [9:0] c);
    req0_valid = v; req0_we = we; req0_row = r; req0_col = c;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [12:0] r, input logic [9:0] c);
    req1_valid = v; req1_we = we; req1_row = r; req1_col = c;
  endtask

  task automatic clear_inputs();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
  endtask

  // Holds reset for a few edges and releases it 1 ns after an edge: the next cycle is cycle 0.
  task automatic apply_reset();
    reset = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  // Scoreboard: every issued command must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_cmd: cycle %0d saw nothing, required cmd %0d at cycle %0d",
                 cyc, exp_q[0].cmd, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (cmd_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_cmd: cycle %0d got cmd %0d row %0d col %0d, required none",
                   cyc, cmd, cmd_row, cmd_col);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc !== mon_e.cyc || cmd !== mon_e.cmd || cmd_row !== mon_e.row || cmd_col !== mon_e.col) begin
            n_bad++;
            $display("FAIL cmd_check: got cyc %0d cmd %0d row %0d col %0d, required cyc %0d cmd %0d row %0d col %0d",
                     cyc, cmd, cmd_row, cmd_col, mon_e.cyc, mon_e.cmd, mon_e.row, mon_e.col);
          end
          if (mon_e.cmd == CMD_RD || mon_e.cmd == CMD_WR) begin
            n_cmp++;
            if (grant_id !== mon_e.gid || req0_ready !== !mon_e.gid || req1_ready !== mon_e.gid) begin
              n_bad++;
              $display("FAIL grant_check: cycle %0d got grant %0d rdy0 %0d rdy1 %0d, required grant %0d",
                       cyc, grant_id, req0_ready, req1_ready, mon_e.gid);
            end
          end
        end
      end
      if (!(cmd_valid && (cmd == CMD_RD || cmd == CMD_WR)) && (req0_ready || req1_ready)) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_ready: cycle %0d got rdy0 %0d rdy1 %0d, required 0 0", cyc, req0_ready, req1_ready);
      end
    end
  end

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({cmd_valid, cmd, cmd_row, cmd_col, grant_id, req0_ready, req1_ready, refresh_pending, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid %0d cmd %0d row %0d col %0d busy %0d pend %0d, required all 0",
               cmd_valid, cmd, cmd_row, cmd_col, busy, refresh_pending);
    end
    apply_reset();
    run_until(2);
    n_cmp++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy %0d valid %0d, required 0 0", busy, cmd_valid);
    end
  endtask

  task automatic test_read_hit();
    clear_inputs();
    drive0(1'b1, 1'b0, 13'd5, 10'd7);
    apply_reset();
    push(1, CMD_ACT, 13'd5, 10'd0, 1'b0);
    push(4, CMD_RD, 13'd0, 10'd7, 1'b0);
    run_until(2);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_open: cycle 2 got %0d, required 1", busy);
    end
    run_until(4);
    drive0(1'b0, 1'b0, '0, '0);
    run_until(6);
    drive0(1'b1, 1'b0, 13'd5, 10'd8);
    push(7, CMD_RD, 13'd0, 10'd8, 1'b0);
    run_until(7);
    drive0(1'b0, 1'b0, '0, '0);
    run_until(12);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL read_hit_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_row_miss();
    clear_inputs();
    drive0(1'b1, 1'b1, 13'd5, 10'd3);
    apply_reset();
    push(1, CMD_ACT, 13'd5, 10'd0, 1'b0);
    push(4, CMD_WR, 13'd0, 10'd3, 1'b0);
    run_until(4);
    drive0(1'b1, 1'b0, 13'd9, 10'd1);
    push(7, CMD_PRE, 13'd0, 10'd0, 1'b0);
    push(10, CMD_ACT, 13'd9, 10'd0, 1'b0);
    push(13, CMD_RD, 13'd0, 10'd1, 1'b0);
    run_until(8);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_pre_wait: cycle 8 got %0d, required 1", busy);
    end
    run_until(13);
    drive0(1'b0, 1'b0, '0, '0);
    run_until(16);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL row_miss_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    drive0(1'b1, 1'b0, 13'd5, 10'h10);
    drive1(1'b1, 1'b1, 13'd5, 10'h20);
    apply_reset();
    push(1, CMD_ACT, 13'd5, 10'd0, 1'b0);
    push(4, CMD_RD, 13'd0, 10'h10, 1'b0);
    push(5, CMD_WR, 13'd0, 10'h20, 1'b1);
    push(6, CMD_RD, 13'd0, 10'h11, 1'b0);
    push(7, CMD_WR, 13'd0, 10'h21, 1'b1);
    run_until(4);
    drive0(1'b1, 1'b0, 13'd5, 10'h11);
    run_until(5);
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_pulse: cycle 5 got rdy0 %0d rdy1 %0d, required 0 1", req0_ready, req1_ready);
    end
    drive1(1'b1, 1'b1, 13'd5, 10'h21);
    run_until(6);
    drive0(1'b0, 1'b0, '0, '0);
    run_until(7);
    drive1(1'b0, 1'b0, '0, '0);
    run_until(10);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_refresh();
    clear_inputs();
    drive0(1'b1, 1'b0, 13'd5, 10'd2);
    apply_reset();
    push(1, CMD_ACT, 13'd5, 10'd0, 1'b0);
    push(4, CMD_RD, 13'd0, 10'd2, 1'b0);
    run_until(4);
    drive0(1'b0, 1'b0, '0, '0);
    run_until(99);
    n_cmp++;
    if (refresh_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_early: cycle 99 got %0d, required 0", refresh_pending);
    end
    run_until(100);
    n_cmp++;
    if (refresh_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL pending_rise: cycle 100 got %0d, required 1", refresh_pending);
    end
    drive1(1'b1, 1'b0, 13'd7, 10'd4);
    push(101, CMD_PRE, 13'd0, 10'd0, 1'b0);
    push(104, CMD_REF, 13'd0, 10'd0, 1'b0);
    push(112, CMD_ACT, 13'd7, 10'd0, 1'b0);
    push(115, CMD_RD, 13'd0, 10'd4, 1'b1);
    run_until(103);
    n_cmp++;
    if (refresh_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL pending_hold: cycle 103 got %0d, required 1", refresh_pending);
    end
    run_until(104);
    n_cmp++;
    if (refresh_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_clear: cycle 104 got %0d, required 0", refresh_pending);
    end
    run_until(110);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_rfc: cycle 110 got %0d, required 1", busy);
    end
    run_until(115);
    drive1(1'b0, 1'b0, '0, '0);
    run_until(118);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL refresh_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    drive0(1'b1, 1'b0, 13'd5, 10'd9);
    apply_reset();
    run_until(1);
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd !== CMD_ACT || cmd_row !== 13'd5) begin
      n_bad++;
      $display("FAIL mid_act: cycle 1 got valid %0d cmd %0d row %0d, required 1 1 5", cmd_valid, cmd, cmd_row);
    end
    #1;
    reset = 1'b1;
    mon_en = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_valid, cmd, cmd_row, cmd_col, grant_id, busy} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got valid %0d cmd %0d row %0d busy %0d, required all 0",
               cmd_valid, cmd, cmd_row, busy);
    end
    apply_reset();
    push(1, CMD_ACT, 13'd5, 10'd0, 1'b0);
    push(4, CMD_RD, 13'd0, 10'd9, 1'b0);
    run_until(4);
    drive0(1'b0, 1'b0, '0, '0);
    run_until(8);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_row_miss();
    test_back_to_back();
    test_refresh();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
